// File: rtl/uart_tx_fifo_sched.sv
// ---------------------------------------------------------------------------
// UartTxFifoSched -- module uart_tx_fifo_sched
//
// Purpose:
//   Moves words from the TX first-word-fall-through FIFO into the UART
//   transmit serializer, one frame at a time. A word is popped, offered on a
//   valid/ready handshake, and then the scheduler waits for the serializer
//   to report that the frame has left the line. An optional idle gap follows
//   before the next word may be popped. The block also supports a FIFO
//   flush, a low-watermark interrupt and a saturating parity-error count.
//
// Configuration macro:
//   UART_TX_SCHED_PERR_DROP_EN -- when defined, a head word whose parity
//   flag is set is popped and thrown away in IDLE instead of being sent. It
//   is still counted in o_perr_cnt. When undefined, flagged words are sent
//   like any other word and are still counted.
//
// Parameters:
//   DW      data word width, same as the FIFO data width
//   USED_W  width of the FIFO occupancy count
//   GAP_W   width of the inter-frame gap counter
//
// Ports:
//   i_clk                clock
//   i_nrst               asynchronous active-low reset
//   i_enable             allows new pops from IDLE
//   i_flush              level request to discard all queued FIFO words
//   i_gap_cycles         idle cycles inserted after i_tx_done
//   i_threshold          low-watermark level for o_thr_irq
//   i_fifo_valid         FIFO head word valid
//   i_fifo_data          FIFO head word
//   i_fifo_parity_error  parity flag of the head word
//   i_fifo_used          FIFO occupancy
//   o_fifo_rd_req        combinational pop strobe, one cycle per word
//   o_tx_valid           word offered to the serializer
//   o_tx_data            offered word
//   i_tx_ready           serializer accepts the offered word
//   i_tx_done            one-cycle pulse: frame fully shifted out
//   o_busy               scheduler is not idle
//   o_flush_done         one-cycle pulse when a flush has finished
//   o_thr_irq            registered low-watermark interrupt
//   o_perr_cnt           saturating count of parity-flagged popped words
// ---------------------------------------------------------------------------
module uart_tx_fifo_sched #(
   parameter int DW     = 8,
   parameter int USED_W = 3,
   parameter int GAP_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              i_enable,
   input  logic              i_flush,
   input  logic [GAP_W-1:0]  i_gap_cycles,
   input  logic [USED_W-1:0] i_threshold,
   input  logic              i_fifo_valid,
   input  logic [DW-1:0]     i_fifo_data,
   input  logic              i_fifo_parity_error,
   input  logic [USED_W-1:0] i_fifo_used,
   output logic              o_fifo_rd_req,
   output logic              o_tx_valid,
   output logic [DW-1:0]     o_tx_data,
   input  logic              i_tx_ready,
   input  logic              i_tx_done,
   output logic              o_busy,
   output logic              o_flush_done,
   output logic              o_thr_irq,
   output logic [7:0]        o_perr_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_DONE,
      ST_GAP,
      ST_FLUSH
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [DW-1:0]    tx_data_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_cnt_next;
   logic [7:0]       perr_cnt;
   logic             load_data;
   logic             perr_inc;
   logic             flush_done_next;

   // Next-state and pop logic. IDLE is the only state that pops a word for
   // transmission and the only state where parity errors are counted, so
   // words discarded by a flush never touch the counter. A flush requested
   // while a frame is in flight is only honoured once i_tx_done arrives, so
   // an offered word is never withdrawn before the serializer has taken it.
   // The gap counter leaves GAP on the cycle it reads 1, which places the
   // next possible pop gap+1 cycles after the i_tx_done pulse.
   always_comb begin
      state_next      = state;
      gap_cnt_next    = gap_cnt;
      o_fifo_rd_req   = 1'b0;
      load_data       = 1'b0;
      perr_inc        = 1'b0;
      flush_done_next = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_flush) begin
               state_next = ST_FLUSH;
            end else if (i_enable && i_fifo_valid) begin
               o_fifo_rd_req = 1'b1;
               perr_inc      = i_fifo_parity_error;
`ifdef UART_TX_SCHED_PERR_DROP_EN
               if (!i_fifo_parity_error) begin
                  load_data  = 1'b1;
                  state_next = ST_SEND;
               end
`else
               load_data  = 1'b1;
               state_next = ST_SEND;
`endif
            end
         end
         ST_SEND: begin
            if (i_tx_ready) begin
               state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (i_tx_done) begin
               if (i_flush) begin
                  state_next = ST_FLUSH;
               end else if (i_gap_cycles == '0) begin
                  state_next = ST_IDLE;
               end else begin
                  gap_cnt_next = i_gap_cycles;
                  state_next   = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (i_flush) begin
               state_next = ST_FLUSH;
            end else begin
               if (gap_cnt <= GAP_W'(1)) begin
                  state_next = ST_IDLE;
               end
               if (gap_cnt != '0) begin
                  gap_cnt_next = gap_cnt - GAP_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            o_fifo_rd_req = i_fifo_valid;
            if (!i_fifo_valid && !i_flush) begin
               flush_done_next = 1'b1;
               state_next      = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register plus the datapath registers. The interrupt is a plain
   // registered compare of the current occupancy against the watermark and
   // the parity counter sticks at its maximum instead of wrapping.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state        <= ST_IDLE;
         tx_data_q    <= '0;
         gap_cnt      <= '0;
         perr_cnt     <= '0;
         o_flush_done <= 1'b0;
         o_thr_irq    <= 1'b0;
      end else begin
         state        <= state_next;
         gap_cnt      <= gap_cnt_next;
         o_flush_done <= flush_done_next;
         o_thr_irq    <= i_enable && (i_fifo_used <= i_threshold);
         if (load_data) begin
            tx_data_q <= i_fifo_data;
         end
         if (perr_inc && (perr_cnt != 8'hFF)) begin
            perr_cnt <= perr_cnt + 8'd1;
         end
      end
   end

   // The offer is simply "we are in SEND"; the data register holds the
   // word until the next pop, so it stays stable through any ready stall.
   assign o_tx_valid = (state == ST_SEND);
   assign o_tx_data  = tx_data_q;
   assign o_busy     = (state != ST_IDLE);
   assign o_perr_cnt = perr_cnt;

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// ---------------------------------------------------------------------------
// TbUartTxFifoSched -- module tb_uart_tx_fifo_sched
//
// Purpose:
//   Self-checking bench for uart_tx_fifo_sched. A queue stands in for the
//   FWFT FIFO and a countdown stands in for the serializer, which answers
//   every accepted word with an i_tx_done pulse a fixed number of cycles
//   later. Each scenario task drives stimulus and compares the logged
//   events against values worked out from the scheduler's rules.
//   Honours UART_TX_SCHED_PERR_DROP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_sched;

`ifdef UART_TX_SCHED_PERR_DROP_EN
   localparam bit DROP_PERR = 1'b1;
`else
   localparam bit DROP_PERR = 1'b0;
`endif

   localparam int RUN_SENT   = 0;
   localparam int RUN_DONE   = 1;
   localparam int RUN_FLUSH  = 2;
   localparam int RUN_SETTLE = 3;
   localparam int RUN_XFER   = 4;

   logic       i_clk;
   logic       i_nrst;
   logic       i_enable;
   logic       i_flush;
   logic [7:0] i_gap_cycles;
   logic [2:0] i_threshold;
   logic       i_fifo_valid;
   logic [7:0] i_fifo_data;
   logic       i_fifo_parity_error;
   logic [2:0] i_fifo_used;
   logic       o_fifo_rd_req;
   logic       o_tx_valid;
   logic [7:0] o_tx_data;
   logic       i_tx_ready;
   logic       i_tx_done;
   logic       o_busy;
   logic       o_flush_done;
   logic       o_thr_irq;
   logic [7:0] o_perr_cnt;

   int errors;
   int checks;
   int cyc;
   int done_delay;
   int done_cnt;
   bit rand_ready;
   bit rand_enable;
   bit manual_used;

   logic [7:0] fq_data[$];
   logic       fq_perr[$];
   logic [7:0] sent_log[$];
   int         rd_log[$];
   int         xfer_log[$];
   int         done_log[$];
   int         valid_log[$];
   int         fd_log[$];
   int         idle_log[$];

   logic       obs_rd;
   logic       obs_valid;
   logic       obs_ready;
   logic [7:0] obs_data;
   logic       obs_busy;
   logic       obs_fd;

   uart_tx_fifo_sched #(.DW(8), .USED_W(3), .GAP_W(8)) dut (
      .i_clk               (i_clk),
      .i_nrst              (i_nrst),
      .i_enable            (i_enable),
      .i_flush             (i_flush),
      .i_gap_cycles        (i_gap_cycles),
      .i_threshold         (i_threshold),
      .i_fifo_valid        (i_fifo_valid),
      .i_fifo_data         (i_fifo_data),
      .i_fifo_parity_error (i_fifo_parity_error),
      .i_fifo_used         (i_fifo_used),
      .o_fifo_rd_req       (o_fifo_rd_req),
      .o_tx_valid          (o_tx_valid),
      .o_tx_data           (o_tx_data),
      .i_tx_ready          (i_tx_ready),
      .i_tx_done           (i_tx_done),
      .o_busy              (o_busy),
      .o_flush_done        (o_flush_done),
      .o_thr_irq           (o_thr_irq),
      .o_perr_cnt          (o_perr_cnt)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Hard stop in case a scenario wedges somewhere unexpected.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present the FIFO head (or an empty FIFO with junk data) to the DUT.
   task automatic drive_fifo();
      i_fifo_valid = (fq_data.size() != 0);
      if (i_fifo_valid) begin
         i_fifo_data         = fq_data[0];
         i_fifo_parity_error = fq_perr[0];
      end else begin
         i_fifo_data         = 8'($urandom);
         i_fifo_parity_error = 1'b0;
      end
      if (!manual_used) begin
         i_fifo_used = (fq_data.size() > 7) ? 3'd7 : 3'(fq_data.size());
      end
   endtask

   task automatic push_word(input logic [7:0] data, input logic perr);
      fq_data.push_back(data);
      fq_perr.push_back(perr);
      drive_fifo();
   endtask

   task automatic clear_logs();
      sent_log.delete();
      rd_log.delete();
      xfer_log.delete();
      done_log.delete();
      valid_log.delete();
      fd_log.delete();
      idle_log.delete();
   endtask

   // One clock cycle: sample outputs at the falling edge, let the rising
   // edge happen, then update the FIFO and serializer models and drive the
   // inputs for the next cycle.
   task automatic step();
      @(negedge i_clk);
      obs_rd    = o_fifo_rd_req;
      obs_valid = o_tx_valid;
      obs_ready = i_tx_ready;
      obs_data  = o_tx_data;
      obs_busy  = o_busy;
      obs_fd    = o_flush_done;
      @(posedge i_clk);
      #1;
      if (obs_rd) begin
         rd_log.push_back(cyc);
         if (fq_data.size() != 0) begin
            fq_data.delete(0);
            fq_perr.delete(0);
         end
      end
      if (obs_valid) valid_log.push_back(cyc);
      if (obs_fd) fd_log.push_back(cyc);
      if (!obs_busy) idle_log.push_back(cyc);
      i_tx_done = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) begin
            i_tx_done = 1'b1;
            done_log.push_back(cyc + 1);
         end
      end
      if (obs_valid && obs_ready) begin
         sent_log.push_back(obs_data);
         xfer_log.push_back(cyc);
         done_cnt = done_delay - 1;
      end
      cyc++;
      if (rand_ready) i_tx_ready = ($urandom_range(0, 3) != 0);
      if (rand_enable) i_enable = ($urandom_range(0, 3) != 0);
      drive_fifo();
   endtask

   // Step until a logged event count reaches its target or the budget runs out.
   task automatic run_until(input int kind, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         case (kind)
            RUN_SENT:   ok = (sent_log.size() >= target);
            RUN_DONE:   ok = (done_log.size() >= target);
            RUN_FLUSH:  ok = (fd_log.size() >= target);
            RUN_XFER:   ok = (xfer_log.size() >= target);
            default:    ok = (done_log.size() >= target) && (fq_data.size() == 0) &&
                             (done_cnt <= 0) && !o_busy;
         endcase
         if (!ok) step();
      end
   endtask

   task automatic do_reset();
      i_nrst       = 1'b0;
      fq_data.delete();
      fq_perr.delete();
      done_cnt     = 0;
      done_delay   = 4;
      rand_ready   = 1'b0;
      rand_enable  = 1'b0;
      manual_used  = 1'b0;
      i_enable     = 1'b1;
      i_flush      = 1'b0;
      i_gap_cycles = 8'd0;
      i_threshold  = 3'd0;
      i_tx_ready   = 1'b1;
      i_tx_done    = 1'b0;
      drive_fifo();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_nrst = 1'b1;
      @(posedge i_clk);
      #1;
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset();
      i_threshold = 3'd7;
      i_nrst      = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", o_tx_valid); end
      checks++; if (o_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", o_tx_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_flush_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_done: got %b expected 0", o_flush_done); end
      checks++; if (o_thr_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_thr_irq: got %b expected 0", o_thr_irq); end
      checks++; if (o_perr_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_perr_cnt: got %h expected 00", o_perr_cnt); end
      checks++; if (o_fifo_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_req: got %b expected 0", o_fifo_rd_req); end
      @(negedge i_clk);
      i_nrst = 1'b1;
      @(posedge i_clk);
      #1;
      checks++; if (o_thr_irq !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_thr_irq: got %b expected 1", o_thr_irq); end
   endtask

   task automatic test_basic();
      int c0;
      bit ok;
      do_reset();
      c0 = cyc;
      push_word(8'hA5, 1'b0);
      push_word(8'h3C, 1'b0);
      run_until(RUN_SETTLE, 2, 80, ok);
      repeat (3) step();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got %0d frames expected 2", done_log.size()); end
      checks++; if (rd_log.size() != 2) begin errors++; $display("[TB] FAIL basic_rd_count: got %0d expected 2", rd_log.size()); end
      checks++; if (sent_log.size() != 2 || sent_log[0] !== 8'hA5 || sent_log[1] !== 8'h3C)
         begin errors++; $display("[TB] FAIL basic_data: got %0d words expected A5,3C", sent_log.size()); end
      if (rd_log.size() >= 2 && done_log.size() >= 1 && valid_log.size() >= 1) begin
         checks++; if (rd_log[0] != c0) begin errors++; $display("[TB] FAIL basic_first_pop: got cycle %0d expected %0d", rd_log[0], c0); end
         checks++; if (valid_log[0] != c0 + 1) begin errors++; $display("[TB] FAIL basic_valid_latency: got cycle %0d expected %0d", valid_log[0], c0 + 1); end
         checks++; if (rd_log[1] != done_log[0] + 1) begin errors++; $display("[TB] FAIL basic_second_pop: got cycle %0d expected %0d", rd_log[1], done_log[0] + 1); end
      end
   endtask

   task automatic test_gap();
      int low_in_frame;
      bit ok;
      do_reset();
      i_gap_cycles = 8'd5;
      push_word(8'h5A, 1'b0);
      push_word(8'hC3, 1'b0);
      run_until(RUN_SETTLE, 2, 100, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL gap_timeout: got %0d frames expected 2", done_log.size()); end
      if (rd_log.size() >= 2 && done_log.size() >= 1) begin
         checks++; if (rd_log[1] != done_log[0] + 6) begin errors++; $display("[TB] FAIL gap_second_pop: got cycle %0d expected %0d", rd_log[1], done_log[0] + 6); end
         low_in_frame = 0;
         foreach (idle_log[i]) if (idle_log[i] > rd_log[0] && idle_log[i] < rd_log[1]) low_in_frame++;
         checks++; if (low_in_frame != 0) begin errors++; $display("[TB] FAIL gap_busy: got %0d idle cycles expected 0", low_in_frame); end
      end
   endtask

   task automatic test_ready_stall();
      bit ok;
      do_reset();
      i_tx_ready = 1'b0;
      i_tx_done  = 1'b1;
      step();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_done_ignored: got busy %b expected 0", o_busy); end
      push_word(8'hA5, 1'b0);
      push_word(8'h3C, 1'b0);
      step();
      for (int k = 0; k < 10; k++) begin
         if (k == 3) i_tx_done = 1'b1;
         step();
         checks++; if (obs_valid !== 1'b1 || obs_data !== 8'hA5)
            begin errors++; $display("[TB] FAIL stall_hold: got valid %b data %h expected 1 A5", obs_valid, obs_data); end
      end
      checks++; if (rd_log.size() != 1) begin errors++; $display("[TB] FAIL stall_rd_count: got %0d expected 1", rd_log.size()); end
      i_tx_ready = 1'b1;
      run_until(RUN_SETTLE, 2, 80, ok);
      checks++; if (!ok || sent_log.size() != 2 || sent_log[0] !== 8'hA5 || sent_log[1] !== 8'h3C)
         begin errors++; $display("[TB] FAIL stall_release: got %0d words expected A5,3C", sent_log.size()); end
   endtask

   task automatic test_flush_deferred();
      bit ok;
      do_reset();
      i_gap_cycles = 8'd3;
      done_delay   = 6;
      push_word(8'h11, 1'b0);
      push_word(8'h22, 1'b0);
      push_word(8'h33, 1'b0);
      push_word(8'h44, 1'b0);
      run_until(RUN_XFER, 1, 20, ok);
      i_flush = 1'b1;
      run_until(RUN_DONE, 1, 30, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL flush_frame_done: got %0d done pulses expected 1", done_log.size()); end
      repeat (2) step();
      i_flush = 1'b0;
      run_until(RUN_FLUSH, 1, 30, ok);
      repeat (3) step();
      checks++; if (sent_log.size() != 1 || sent_log[0] !== 8'h11)
         begin errors++; $display("[TB] FAIL flush_sent: got %0d words expected 1 (11)", sent_log.size()); end
      checks++; if (valid_log.size() != 1) begin errors++; $display("[TB] FAIL flush_valid_cycles: got %0d expected 1", valid_log.size()); end
      checks++; if (rd_log.size() != 4) begin errors++; $display("[TB] FAIL flush_rd_count: got %0d expected 4", rd_log.size()); end
      checks++; if (fd_log.size() != 1) begin errors++; $display("[TB] FAIL flush_done_pulses: got %0d expected 1", fd_log.size()); end
      checks++; if (fq_data.size() != 0) begin errors++; $display("[TB] FAIL flush_fifo_left: got %0d expected 0", fq_data.size()); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got busy %b expected 0", o_busy); end
      if (rd_log.size() >= 2 && done_log.size() >= 1) begin
         checks++; if (rd_log[1] != done_log[0] + 1) begin errors++; $display("[TB] FAIL flush_overrides_gap: got cycle %0d expected %0d", rd_log[1], done_log[0] + 1); end
      end
   endtask

   task automatic test_parity();
      bit ok;
      int n_exp;
      do_reset();
      done_delay = 3;
      n_exp = DROP_PERR ? 1 : 2;
      push_word(8'h55, 1'b1);
      push_word(8'h66, 1'b0);
      run_until(RUN_SETTLE, n_exp, 60, ok);
      repeat (2) step();
      checks++; if (!ok || sent_log.size() != n_exp) begin errors++; $display("[TB] FAIL parity_sent_count: got %0d expected %0d", sent_log.size(), n_exp); end
      checks++; if (sent_log.size() == 0 || sent_log[sent_log.size() - 1] !== 8'h66)
         begin errors++; $display("[TB] FAIL parity_last_word: got %0d words expected last 66", sent_log.size()); end
      checks++; if (o_perr_cnt !== 8'd1) begin errors++; $display("[TB] FAIL parity_count: got %0d expected 1", o_perr_cnt); end
      if (DROP_PERR && rd_log.size() >= 2) begin
         checks++; if (rd_log[1] != rd_log[0] + 1) begin errors++; $display("[TB] FAIL parity_drop_next: got cycle %0d expected %0d", rd_log[1], rd_log[0] + 1); end
      end
   endtask

   task automatic test_perr_saturate();
      int pushed;
      bit fin;
      do_reset();
      done_delay = 2;
      pushed = 0;
      fin    = 1'b0;
      for (int k = 0; k < 6000 && !fin; k++) begin
         while (pushed < 260 && fq_data.size() < 4) begin
            push_word(8'(pushed), 1'b1);
            pushed++;
         end
         step();
         if (pushed == 260 && fq_data.size() == 0 && done_log.size() == xfer_log.size() && !o_busy) fin = 1'b1;
      end
      checks++; if (!fin) begin errors++; $display("[TB] FAIL sat_timeout: got %0d pushed expected 260 drained", pushed); end
      checks++; if (o_perr_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 255", o_perr_cnt); end
      checks++; if (sent_log.size() != (DROP_PERR ? 0 : 260))
         begin errors++; $display("[TB] FAIL sat_sent: got %0d expected %0d", sent_log.size(), DROP_PERR ? 0 : 260); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      int perr_exp;
      int n;
      int gap;
      int nxt;
      bit ok;
      logic [7:0] d;
      logic p;
      do_reset();
      perr_exp = 0;
      for (int r = 0; r < 6; r++) begin
         clear_logs();
         exp_q.delete();
         gap          = $urandom_range(0, 4);
         i_gap_cycles = 8'(gap);
         done_delay   = $urandom_range(2, 5);
         rand_ready   = 1'b1;
         rand_enable  = 1'b1;
         n = $urandom_range(1, 5);
         for (int w = 0; w < n; w++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 2) == 0);
            push_word(d, p);
            if (p) perr_exp++;
            if (!(p && DROP_PERR)) exp_q.push_back(d);
         end
         run_until(RUN_SETTLE, exp_q.size(), 600, ok);
         rand_ready  = 1'b0;
         rand_enable = 1'b0;
         i_tx_ready  = 1'b1;
         i_enable    = 1'b1;
         checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_timeout: got %0d frames expected %0d", done_log.size(), exp_q.size()); end
         checks++; if (sent_log.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", sent_log.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < sent_log.size(); i++) begin
            checks++; if (sent_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_word%0d: got %h expected %h", i, sent_log[i], exp_q[i]); end
         end
         checks++; if (o_perr_cnt !== 8'(perr_exp)) begin errors++; $display("[TB] FAIL rand_perr: got %0d expected %0d", o_perr_cnt, perr_exp); end
         foreach (done_log[i]) begin
            nxt = -1;
            foreach (rd_log[j]) if (nxt < 0 && rd_log[j] > done_log[i]) nxt = rd_log[j];
            if (nxt >= 0) begin
               checks++; if (nxt < done_log[i] + gap + 1)
                  begin errors++; $display("[TB] FAIL rand_gap: got pop at %0d expected >= %0d", nxt, done_log[i] + gap + 1); end
            end
         end
      end
   endtask

   task automatic test_threshold();
      logic [2:0] u;
      logic [2:0] t;
      logic       e;
      logic       exp;
      do_reset();
      manual_used = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (k == 0) begin u = 3'd1; t = 3'd2; e = 1'b1; end
         else if (k == 1) begin u = 3'd3; t = 3'd3; e = 1'b1; end
         else if (k == 2) begin u = 3'd4; t = 3'd3; e = 1'b1; end
         else if (k == 3) begin u = 3'd0; t = 3'd7; e = 1'b0; end
         else begin u = 3'($urandom); t = 3'($urandom); e = 1'($urandom); end
         i_fifo_used = u;
         i_threshold = t;
         i_enable    = e;
         exp = e && (u <= t);
         @(posedge i_clk);
         #1;
         checks++; if (o_thr_irq !== exp) begin errors++; $display("[TB] FAIL thr_irq_%0d: got %b expected %b (used %0d thr %0d en %b)", k, o_thr_irq, exp, u, t, e); end
      end
      manual_used = 1'b0;
      i_enable    = 1'b1;
      drive_fifo();
   endtask

   task automatic test_reset_midframe();
      int c0;
      bit ok;
      do_reset();
      i_tx_ready = 1'b0;
      push_word(8'hA5, 1'b0);
      repeat (2) step();
      checks++; if (o_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid: got %b expected 1", o_tx_valid); end
      #2;
      i_nrst = 1'b0;
      #1;
      checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", o_tx_valid); end
      checks++; if (o_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 00", o_tx_data); end
      @(posedge i_clk);
      #2;
      i_nrst = 1'b1;
      @(posedge i_clk);
      #1;
      clear_logs();
      i_tx_ready = 1'b1;
      repeat (5) step();
      checks++; if (valid_log.size() != 0 || rd_log.size() != 0)
         begin errors++; $display("[TB] FAIL midrst_quiet: got %0d valid %0d pops expected 0 0", valid_log.size(), rd_log.size()); end
      c0 = cyc;
      push_word(8'h3C, 1'b0);
      run_until(RUN_SETTLE, 1, 40, ok);
      checks++; if (!ok || valid_log.size() == 0 || valid_log[0] != c0 + 1)
         begin errors++; $display("[TB] FAIL midrst_fresh_valid: got %0d valid cycles expected first at %0d", valid_log.size(), c0 + 1); end
      checks++; if (sent_log.size() != 1 || sent_log[0] !== 8'h3C)
         begin errors++; $display("[TB] FAIL midrst_fresh_data: got %0d words expected 3C", sent_log.size()); end
   endtask

   // Scenario sequence; every task starts from a fresh reset.
   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      i_nrst = 1'b0;
      test_reset();
      test_basic();
      test_gap();
      test_ready_stall();
      test_flush_deferred();
      test_parity();
      test_perr_saturate();
      test_random();
      test_threshold();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
